// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the word-serial MixColumns engine.
//   word_t / state_t : one 32-bit column / the full 128-bit state
//   mc_state_t       : sequencer states of inv_mix_columns_seq
//   xtime            : multiply by x (02) modulo the AES polynomial
//   gf_mul_const     : multiply by one of the MixColumns coefficients
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  localparam logic [7:0] AES_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Only the coefficients used by (Inv)MixColumns are supported; any other
  // constant yields zero so a typo shows up loudly rather than silently.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] x,
                                              input logic [7:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h01:   return x;
      8'h02:   return x2;
      8'h03:   return x2 ^ x;
      8'h09:   return x8 ^ x;
      8'h0b:   return x8 ^ x2 ^ x;
      8'h0d:   return x8 ^ x4 ^ x;
      8'h0e:   return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational (Inv)MixColumns transform of a single 32-bit column.
//   col_in  : column, byte b0 in [31:24] ... b3 in [7:0]
//   col_out : transformed column, same byte order
// INVERSE=1 uses coefficients (0e 0b 0d 09), INVERSE=0 uses (02 03 01 01).
module mix_column_word
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  word_t col_in,
  output word_t col_out
);

  localparam logic [7:0] C0 = INVERSE ? 8'h0e : 8'h02;
  localparam logic [7:0] C1 = INVERSE ? 8'h0b : 8'h03;
  localparam logic [7:0] C2 = INVERSE ? 8'h0d : 8'h01;
  localparam logic [7:0] C3 = INVERSE ? 8'h09 : 8'h01;

  logic [7:0] b [4];
  logic [7:0] o [4];

  always_comb begin
    b[0] = col_in[31:24];
    b[1] = col_in[23:16];
    b[2] = col_in[15:8];
    b[3] = col_in[7:0];
  end

  // Row i of the circulant matrix: coefficient j multiplies b[(i+j) mod 4].
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      o[i] = gf_mul_const(b[i], C0)
           ^ gf_mul_const(b[(i + 1) % 4], C1)
           ^ gf_mul_const(b[(i + 2) % 4], C2)
           ^ gf_mul_const(b[(i + 3) % 4], C3);
    end
  end

  assign col_out = {o[0], o[1], o[2], o[3]};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Word-serial (Inv)MixColumns engine: one column per clock over four RUN
// cycles, streaming each result word and assembling the full state.
//   CLK, RESET_N : clock (rising edge), asynchronous active-low reset
//   start        : request, sampled only in IDLE
//   state_in     : 128-bit state, column 0 = [127:96]; captured on accept
//   busy         : high in RUN
//   word_valid   : high in RUN; word_out/word_sel valid that cycle
//   word_sel     : column index of word_out
//   word_out     : transformed column (zero outside RUN)
//   result_out   : assembled transformed state, held after DONE
//   done         : one-cycle pulse once result_out is complete
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         word_valid,
  output logic [1:0]   word_sel,
  output logic [31:0]  word_out,
  output logic [127:0] result_out,
  output logic         done
);

  mc_state_t fsm_q, fsm_d;
  logic [1:0] idx_q, idx_d;
  state_t     cap_q, cap_d;
  state_t     result_q, result_d;

  word_t col_in, col_out;

  always_comb begin
    col_in = cap_q[127:96];
    case (idx_q)
      2'd1:    col_in = cap_q[95:64];
      2'd2:    col_in = cap_q[63:32];
      2'd3:    col_in = cap_q[31:0];
      default: col_in = cap_q[127:96];
    endcase
  end

  // Single transform instance, time-shared across the four columns.
  mix_column_word #(.INVERSE(INVERSE)) u_mix (
    .col_in  (col_in),
    .col_out (col_out)
  );

  always_comb begin
    fsm_d    = fsm_q;
    idx_d    = idx_q;
    cap_d    = cap_q;
    result_d = result_q;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          cap_d = state_in;
          idx_d = 2'd0;
          fsm_d = RUN;
        end
      end
      RUN: begin
        case (idx_q)
          2'd0:    result_d[127:96] = col_out;
          2'd1:    result_d[95:64]  = col_out;
          2'd2:    result_d[63:32]  = col_out;
          default: result_d[31:0]   = col_out;
        endcase
        // Index wraps 3 -> 0, so word_sel reads 0 again outside RUN.
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) fsm_d = DONE;
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm_q    <= IDLE;
      idx_q    <= 2'd0;
      cap_q    <= '0;
      result_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      result_q <= result_d;
    end
  end

  // Outputs decode directly from registered state, so they follow an
  // asynchronous reset immediately.
  assign busy       = (fsm_q == RUN);
  assign word_valid = (fsm_q == RUN);
  assign done       = (fsm_q == DONE);
  assign word_sel   = idx_q;
  assign word_out   = (fsm_q == RUN) ? col_out : 32'h0;
  assign result_out = result_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench: a forward and an inverse instance share clock and
// reset; every cycle of every operation is checked against a GF(2^8)
// shift-and-add reference model.
module tb_inv_mix_columns_seq;

  logic         CLK;
  logic         RESET_N;
  logic         start_f, start_i;
  logic [127:0] state_f, state_i;
  logic         busy_f, busy_i, wv_f, wv_i, done_f, done_i;
  logic [1:0]   sel_f, sel_i;
  logic [31:0]  wout_f, wout_i;
  logic [127:0] res_f, res_i;

  inv_mix_columns_seq #(.INVERSE(1'b0)) u_fwd (
    .CLK(CLK), .RESET_N(RESET_N), .start(start_f), .state_in(state_f),
    .busy(busy_f), .word_valid(wv_f), .word_sel(sel_f), .word_out(wout_f),
    .result_out(res_f), .done(done_f)
  );

  inv_mix_columns_seq #(.INVERSE(1'b1)) u_inv (
    .CLK(CLK), .RESET_N(RESET_N), .start(start_i), .state_in(state_i),
    .busy(busy_i), .word_valid(wv_i), .word_sel(sel_i), .word_out(wout_i),
    .result_out(res_i), .done(done_i)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Observed signals of the instance currently under test.
  bit           mode;
  logic         busy_m, wv_m, done_m;
  logic [1:0]   sel_m;
  logic [31:0]  wout_m;
  logic [127:0] res_m;
  always_comb begin
    busy_m = mode ? busy_i : busy_f;
    wv_m   = mode ? wv_i   : wv_f;
    done_m = mode ? done_i : done_f;
    sel_m  = mode ? sel_i  : sel_f;
    wout_m = mode ? wout_i : wout_f;
    res_m  = mode ? res_i  : res_f;
  end

  // Last completed result per instance (what result_out should be holding).
  logic [127:0] prev [2];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model: generic GF(2^8) multiply, matrix-row definition ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_col(input bit inv, input logic [31:0] w);
    logic [7:0] by [4];
    logic [7:0] c  [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) by[i] = w[31 - 8*i -: 8];
    if (inv) begin c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09; end
    else     begin c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01; end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] acc;
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(c[j], by[(i + j) % 4]);
      r[31 - 8*i -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_state(input bit inv, input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[127 - 32*k -: 32] = ref_col(inv, s[127 - 32*k -: 32]);
    return r;
  endfunction

  // Slots below k already rewritten with the new result, the rest still old.
  function automatic logic [127:0] partial(input logic [127:0] p,
                                           input logic [127:0] e, input int k);
    logic [127:0] r;
    r = p;
    for (int j = 0; j < k; j++) r[127 - 32*j -: 32] = e[127 - 32*j -: 32];
    return r;
  endfunction

  function automatic logic [127:0] rnd_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_in(input bit m, input logic st, input logic [127:0] s);
    if (m) begin start_i = st; state_i = s; end
    else   begin start_f = st; state_f = s; end
  endtask

  // Called in an IDLE cycle (at the falling edge); returns in the IDLE cycle
  // after DONE, so consecutive calls exercise back-to-back starts.
  task automatic run_op(input bit m, input logic [127:0] s, input bit pulse,
                        output logic [127:0] r);
    logic [127:0] e, p;
    mode = m;
    e = ref_state(m, s);
    p = prev[m];
    set_in(m, 1'b1, s);
    @(negedge CLK);
    set_in(m, 1'b0, rnd_state());
    for (int k = 0; k < 4; k++) begin
      if (pulse && k == 1) set_in(m, 1'b1, rnd_state());
      if (pulse && k == 2) set_in(m, 1'b0, rnd_state());
      chk("busy_run", busy_m, 1);
      chk("wvalid_run", wv_m, 1);
      chk("word_sel", sel_m, k[1:0]);
      chk("word_out", wout_m, e[127 - 32*k -: 32]);
      chk("result_partial", res_m, partial(p, e, k));
      chk("done_run", done_m, 0);
      @(negedge CLK);
    end
    chk("done_pulse", done_m, 1);
    chk("busy_done", busy_m, 0);
    chk("result_done", res_m, e);
    r = res_m;
    prev[m] = e;
    @(negedge CLK);
    chk("done_idle", done_m, 0);
    chk("busy_idle", busy_m, 0);
    chk("result_hold", res_m, e);
  endtask

  logic [127:0] r1, r2, x;

  initial begin
    RESET_N = 1'b0;
    start_f = 1'b0; start_i = 1'b0;
    state_f = '0;   state_i = '0;
    mode = 1'b1;
    prev[0] = '0; prev[1] = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy_i, 0);
    chk("rst_wvalid", wv_i, 0);
    chk("rst_done", done_i, 0);
    chk("rst_sel", sel_i, 0);
    chk("rst_result", res_i, 0);
    chk("rst_result_f", res_f, 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("idle_busy", busy_i, 0);

    // Directed vectors.
    run_op(1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, r1);
    chk("vec_inv", r1, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    run_op(1'b0, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 1'b0, r1);
    chk("vec_fwd", r1, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8);

    // Back-to-back with a stray start pulse during RUN.
    run_op(1'b1, rnd_state(), 1'b1, r1);
    run_op(1'b1, rnd_state(), 1'b0, r1);
    @(negedge CLK);
    chk("no_extra_busy", busy_i, 0);
    chk("no_extra_done", done_i, 0);

    // start held high: one operation every 6 cycles.
    mode = 1'b0;
    x = rnd_state();
    set_in(1'b0, 1'b1, x);
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      chk("hold_done", done_f, (c % 6) == 5);
      chk("hold_busy", busy_f, ((c % 6) >= 1) && ((c % 6) <= 4));
      if ((c % 6) == 5) chk("hold_result", res_f, ref_state(1'b0, x));
    end
    set_in(1'b0, 1'b0, x);
    prev[0] = ref_state(1'b0, x);
    @(negedge CLK);
    chk("hold_stop", busy_f, 0);

    // Reset in the middle of RUN.
    mode = 1'b1;
    set_in(1'b1, 1'b1, rnd_state());
    @(negedge CLK);
    set_in(1'b1, 1'b0, '0);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("mrst_busy", busy_i, 0);
    chk("mrst_wvalid", wv_i, 0);
    chk("mrst_done", done_i, 0);
    chk("mrst_result", res_i, 0);
    prev[0] = '0; prev[1] = '0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("mrst_idle_done", done_i, 0);
    run_op(1'b1, rnd_state(), 1'b0, r1);

    // Round trip forward then inverse.
    for (int n = 0; n < 1000; n++) begin
      x = rnd_state();
      run_op(1'b0, x, 1'b0, r1);
      run_op(1'b1, r1, 1'b0, r2);
      chk("round_trip", r2, x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Word-serial (Inv)MixColumns engine for the AES decrypt/encrypt datapath.
- Accepts a 128-bit state and processes one 32-bit column per clock, four clocks in total.
- Streams each transformed column with its 2-bit word index, ready for the downstream 32→128 word-assembly register.
- Also assembles the full 128-bit result internally and pulses done when the state is complete.

Parameters:
INVERSE, 1, 1 = InvMixColumns (coefficients 0e 0b 0d 09); 0 = forward MixColumns (02 03 01 01)

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
state_in  input  128  AES state; column 0 = [127:96] … column 3 = [31:0]; captured on the accepted start
busy  output  1  high while in RUN
word_valid  output  1  high in each RUN cycle; word_out/word_sel are valid that cycle
word_sel  output  2  column index of word_out (0 → [127:96], 3 → [31:0])
word_out  output  32  transformed column
result_out  output  128  assembled transformed state
done  output  1  one-cycle pulse; result_out is complete

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state = IDLE; idx = 0; captured state = 0.
  - busy, word_valid, done = 0; word_sel = 0; result_out = 0.
- FSM states and transitions:
  - IDLE: if start, capture state_in, set idx = 0, go to RUN; otherwise hold.
  - RUN:
    - word_valid = 1, busy = 1, word_sel = idx.
    - word_out = f(column idx of the captured state), combinational from registers.
    - On the clock edge, write word_out into the result_out slot selected by idx (idx 0 → [127:96]).
    - If idx == 3, go to DONE; otherwise idx increments by 1.
  - DONE: done = 1 for exactly one cycle; go to IDLE.
- Latency:
  - Start accepted at edge 0.
  - RUN occupies cycles 1–4 (word_sel 0, 1, 2, 3, in that order).
  - done is high in cycle 5.
  - The next start can be accepted at the end of that DONE cycle, i.e. in the following IDLE cycle.
- result_out:
  - Updated slot by slot during RUN.
  - Holds its value unchanged after DONE until the next RUN overwrites it.
- start while busy or in DONE is ignored (not queued). state_in changes after capture have no effect.
- Column transform, with bytes b0..b3 where b0 = the column's most-significant byte:
  - out_i = c0·b_i ⊕ c1·b_(i+1) ⊕ c2·b_(i+2) ⊕ c3·b_(i+3), indices mod 4.
  - (c0..c3) = (0e, 0b, 0d, 09) when INVERSE = 1; (02, 03, 01, 01) when INVERSE = 0.
- GF(2^8) arithmetic:
  - xtime(x) = {x[6:0], 0} ⊕ (x[7] ? 8'h1b : 0).
  - 09 = x8 ⊕ x; 0b = x8 ⊕ x2 ⊕ x; 0d = x8 ⊕ x4 ⊕ x; 0e = x8 ⊕ x4 ⊕ x2, where x2 = xtime(x), x4 = xtime(x2), x8 = xtime(x4).
  - All products are 8-bit; no carries beyond bit 7.
- Reset mid-RUN: outputs return to reset values immediately; a partial result is discarded, with no done.
- start asserted in the same cycle reset deasserts: not accepted; the first sampling edge is the one after RESET_N is high.
- The engine is purely combinational per column, so there are no multicycle paths.

Decomposition:
- Package aes_pkg holds:
  - typedef word_t (logic [31:0]) and typedef state_t (logic [127:0]).
  - enum mc_state_t {IDLE, RUN, DONE}.
  - Constant AES_POLY = 8'h1b.
  - Functions xtime and gf_mul_const (multiply by 01/02/03/09/0b/0d/0e).
- Sub-module mix_column_word (parameter INVERSE; word_t in → word_t out; combinational). It is instantiated once and reused each RUN cycle.

Test Plan:
- INVERSE=1, state_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, start 1 cycle:
  - word_out sequence db135345, f20a225c, 01010101, c6c6c6c6 with word_sel 0..3.
  - done in cycle 5; result_out = db135345_f20a225c_01010101_c6c6c6c6.
- INVERSE=0, state_in = db135345_f20a225c_d4d4d4d5_2d26314c:
  - result_out = 8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8.
- Round trip: forward instance followed by inverse instance on a random 128-bit state → output equals input, over 1000 random states.
- start held high continuously: one operation per 6 cycles; a pulse of start during RUN does not alter the result or trigger an extra done.
- RESET_N low at RUN cycle 2: busy, word_valid, done and result_out go to 0 asynchronously. After release, a fresh start gives the correct result.
- Back-to-back: second start in the first IDLE cycle after DONE; result_out holds its first value until its slots are overwritten, and the second done carries the correct second result.
